// File: rtl/fb_blit_pkg.sv
// Shared constants for the blitter address generator: CPU register map,
// control/mode bit positions and status byte layout.
package fb_blit_pkg;

    // CPU register addresses
    localparam logic [1:0] REG_YSTART = 2'd0;
    localparam logic [1:0] REG_XSTART = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_MODE   = 2'd3;

    // REG_CTRL bit positions
    localparam int CTRL_YF     = 7;
    localparam int CTRL_XF     = 6;
    localparam int CTRL_IRQDIS = 5;

    // REG_MODE bit positions
    localparam int MODE_FLIPCNT = 0;
    localparam int MODE_CLAMP   = 1;
    localparam int MODE_FXOR    = 2;

    // Status byte bit positions
    localparam int ST_INT = 7;
    localparam int ST_OVR = 6;

    // Assemble the status/mode readback byte
    function automatic logic [7:0] status_byte(input logic int_v,
                                               input logic ovr_v,
                                               input logic [2:0] mode_v);
        logic [7:0] b;
        b = 8'h00;
        b[ST_INT] = int_v;
        b[ST_OVR] = ovr_v;
        b[2:0]    = mode_v;
        return b;
    endfunction

endpackage

// File: rtl/fb_axis_counter.sv
// Loadable up/down axis counter with optional saturation at the ends of
// its range. Load has priority over step.
module fb_axis_counter #(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         nRESET,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         step,
    input  logic         down,
    input  logic         clamp,
    output logic [W-1:0] value
);

    localparam logic [W-1:0] ONE_C  = W'(1'b1);
    localparam logic [W-1:0] ZERO_C = {W{1'b0}};
    localparam logic [W-1:0] ONES_C = {W{1'b1}};

    logic [W-1:0] cnt_r;
    logic [W-1:0] cnt_nxt_s;

    // Next count: load, else step in the requested direction with wrap or hold
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (load) begin
            cnt_nxt_s = load_val;
        end else if (step) begin
            if (down) begin
                if (clamp && (cnt_r == ZERO_C)) begin
                    cnt_nxt_s = cnt_r;
                end else begin
                    cnt_nxt_s = cnt_r - ONE_C;
                end
            end else begin
                if (clamp && (cnt_r == ONES_C)) begin
                    cnt_nxt_s = cnt_r;
                end else begin
                    cnt_nxt_s = cnt_r + ONE_C;
                end
            end
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Count register
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            cnt_r <= ZERO_C;
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end

    assign value = cnt_r;

endmodule

// File: rtl/fb_blit_addr_gen.sv
// Sprite/blit framebuffer address generator: CPU-programmed start position,
// flips and palette; Y-line and X-pixel-pair counters; multiplexed DRAM
// row/column address over a double-buffered {frame, Y, X} map; interrupt
// with overrun flag.
module fb_blit_addr_gen
    import fb_blit_pkg::*;
#(
    parameter int XW   = 7,
    parameter int YW   = 8,
    parameter int PALW = 5,
    parameter int DW   = 8
) (
    input  logic            CLK,
    input  logic            nRESET,
    input  logic            CS,
    input  logic            WR,
    input  logic [1:0]      A,
    input  logic [7:0]      D,
    output logic [7:0]      Q,
    input  logic            LOAD,
    input  logic            LINE_STEP,
    input  logic            PIX_STEP,
    input  logic            BLK,
    input  logic            PHASE,
    input  logic            FRAME,
    output logic [DW-1:0]   DRAM_A,
    output logic            DRAM_OE,
    output logic [PALW-1:0] PAL,
    output logic            PAL_OE,
    output logic            XF,
    output logic            YF,
    output logic            S,
    output logic            PLUSONE,
    output logic            INT,
    input  logic            ACK
);

    generate
        if (1 + YW + XW != 2 * DW) begin : g_bad_dw
            $error("fb_blit_addr_gen: 1+YW+XW must equal 2*DW");
        end
    endgenerate

    logic [7:0]      reg0_r;
    logic [7:0]      reg1_r;
    logic [7:0]      reg2_r;
    logic [2:0]      reg3_r;
    logic [PALW-1:0] pal_r;
    logic            xf_r;
    logic            yf_r;
    logic            half_r;
    logic            int_r;
    logic            ovr_r;
    logic            pal_oe_r;

    logic            wr_en_s;
    logic            ctrl_dis_wr_s;
    logic            irq_set_s;
    logic            irq_clr_s;
    logic            y_step_s;
    logic            x_load_s;
    logic            x_step_s;
    logic [YW-1:0]   y_s;
    logic [XW-1:0]   x_s;
    logic [2*DW-1:0] addr_s;
    logic [7:0]      q_s;

    assign wr_en_s       = CS & WR;
    assign ctrl_dis_wr_s = wr_en_s & (A == REG_CTRL) & D[CTRL_IRQDIS];
    assign irq_set_s     = LOAD & ~reg2_r[CTRL_IRQDIS] & ~ctrl_dis_wr_s;
    assign irq_clr_s     = ACK | ctrl_dis_wr_s;

    // LOAD outranks LINE_STEP, which outranks PIX_STEP
    assign y_step_s = ~LOAD & LINE_STEP;
    assign x_load_s = LOAD | LINE_STEP;
    assign x_step_s = ~LOAD & ~LINE_STEP & PIX_STEP & BLK;

    // CPU-visible register file
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            reg0_r <= 8'h00;
            reg1_r <= 8'h00;
            reg2_r <= 8'h00;
            reg3_r <= 3'b000;
        end else if (wr_en_s) begin
            case (A)
                REG_YSTART: reg0_r <= D;
                REG_XSTART: reg1_r <= D;
                REG_CTRL:   reg2_r <= D;
                REG_MODE:   reg3_r <= D[2:0];
                default:    reg3_r <= reg3_r;
            endcase
        end else begin
            reg0_r <= reg0_r;
        end
    end

    // Per-object latches captured at start of object
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            pal_r  <= {PALW{1'b0}};
            xf_r   <= 1'b0;
            yf_r   <= 1'b0;
            half_r <= 1'b0;
        end else if (LOAD) begin
            pal_r  <= reg2_r[PALW-1:0];
            xf_r   <= reg2_r[CTRL_XF];
            yf_r   <= reg2_r[CTRL_YF];
            half_r <= reg1_r[0];
        end else begin
            pal_r  <= pal_r;
        end
    end

    // Interrupt and overrun: a set on LOAD beats a simultaneous clear
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            int_r <= 1'b0;
            ovr_r <= 1'b0;
        end else if (irq_set_s) begin
            int_r <= 1'b1;
            ovr_r <= int_r & ~irq_clr_s;
        end else if (irq_clr_s) begin
            int_r <= 1'b0;
            ovr_r <= 1'b0;
        end else begin
            int_r <= int_r;
        end
    end

    // Palette bus enable lags blanking by one cycle
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            pal_oe_r <= 1'b0;
        end else begin
            pal_oe_r <= ~BLK;
        end
    end

    fb_axis_counter #(.W(YW)) u_y_cnt (
        .CLK      (CLK),
        .nRESET   (nRESET),
        .load     (LOAD),
        .load_val (reg0_r[YW-1:0]),
        .step     (y_step_s),
        .down     (yf_r & reg3_r[MODE_FLIPCNT]),
        .clamp    (reg3_r[MODE_CLAMP]),
        .value    (y_s)
    );

    fb_axis_counter #(.W(XW)) u_x_cnt (
        .CLK      (CLK),
        .nRESET   (nRESET),
        .load     (x_load_s),
        .load_val (reg1_r[XW:1]),
        .step     (x_step_s),
        .down     (xf_r & reg3_r[MODE_FLIPCNT]),
        .clamp    (reg3_r[MODE_CLAMP]),
        .value    (x_s)
    );

    assign addr_s = {FRAME ^ reg3_r[MODE_FXOR], y_s, x_s};

    // CPU readback mux, side-effect free
    always_comb begin
        q_s = 8'h00;
        case (A)
            REG_YSTART: q_s = reg0_r;
            REG_XSTART: q_s = reg1_r;
            REG_CTRL:   q_s = reg2_r;
            REG_MODE:   q_s = status_byte(int_r, ovr_r, reg3_r);
            default:    q_s = 8'h00;
        endcase
    end

    assign Q       = q_s;
    assign DRAM_A  = PHASE ? addr_s[2*DW-1:DW] : addr_s[DW-1:0];
    assign DRAM_OE = BLK;
    assign PAL     = pal_r;
    assign PAL_OE  = pal_oe_r;
    assign XF      = xf_r;
    assign YF      = yf_r;
    assign S       = half_r ^ xf_r;
    assign PLUSONE = half_r & BLK;
    assign INT     = int_r;

endmodule

// File: tb/tb_fb_blit_addr_gen.sv
// Directed self-checking bench for fb_blit_addr_gen.
module tb_fb_blit_addr_gen;

    logic       CLK = 1'b0;
    logic       nRESET;
    logic       CS, WR, LOAD, LINE_STEP, PIX_STEP, BLK, PHASE, FRAME, ACK;
    logic [1:0] A;
    logic [7:0] D;
    logic [7:0] Q;
    logic [7:0] DRAM_A;
    logic       DRAM_OE;
    logic [4:0] PAL;
    logic       PAL_OE, XF, YF, S, PLUSONE, INT;

    int tests_run    = 0;
    int tests_failed = 0;

    fb_blit_addr_gen dut (
        .CLK(CLK), .nRESET(nRESET), .CS(CS), .WR(WR), .A(A), .D(D), .Q(Q),
        .LOAD(LOAD), .LINE_STEP(LINE_STEP), .PIX_STEP(PIX_STEP), .BLK(BLK),
        .PHASE(PHASE), .FRAME(FRAME), .DRAM_A(DRAM_A), .DRAM_OE(DRAM_OE),
        .PAL(PAL), .PAL_OE(PAL_OE), .XF(XF), .YF(YF), .S(S),
        .PLUSONE(PLUSONE), .INT(INT), .ACK(ACK)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        CS = 1'b1; WR = 1'b1; A = a; D = d;
        cyc();
        CS = 1'b0; WR = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [1:0] a, input logic [7:0] exp);
        A = a;
        #1;
        chk(tag, {8'h00, Q}, {8'h00, exp});
    endtask

    task automatic load();
        LOAD = 1'b1; cyc(); LOAD = 1'b0;
    endtask

    task automatic ack();
        ACK = 1'b1; cyc(); ACK = 1'b0;
    endtask

    task automatic chk_addr(input string tag, input logic [7:0] exp_hi, input logic [7:0] exp_lo);
        PHASE = 1'b1; #1;
        chk({tag, "_row"}, {8'h00, DRAM_A}, {8'h00, exp_hi});
        PHASE = 1'b0; #1;
        chk({tag, "_col"}, {8'h00, DRAM_A}, {8'h00, exp_lo});
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        nRESET = 1'b0; CS = 1'b0; WR = 1'b0; A = 2'd0; D = 8'h00;
        LOAD = 1'b0; LINE_STEP = 1'b0; PIX_STEP = 1'b0; BLK = 1'b1;
        PHASE = 1'b0; FRAME = 1'b0; ACK = 1'b0;
        #3;
        // reset state
        rd("rst_q0", 2'd0, 8'h00);
        rd("rst_q1", 2'd1, 8'h00);
        rd("rst_q2", 2'd2, 8'h00);
        rd("rst_q3", 2'd3, 8'h00);
        chk("rst_int", {15'd0, INT}, 16'd0);
        chk("rst_paloe", {15'd0, PAL_OE}, 16'd0);
        chk("rst_dramoe", {15'd0, DRAM_OE}, 16'd1);
        cyc(); cyc();
        chk("rst_paloe_held", {15'd0, PAL_OE}, 16'd0);
        nRESET = 1'b1;
        cyc();

        // basic address map
        wr(2'd0, 8'h10); wr(2'd1, 8'h0A); wr(2'd2, 8'h03);
        load();
        chk_addr("map", 8'h08, 8'h05);
        chk("map_pal", {11'd0, PAL}, 16'd3);
        chk("map_s", {15'd0, S}, 16'd0);
        chk("map_plusone", {15'd0, PLUSONE}, 16'd0);
        rd("rb_reg0", 2'd0, 8'h10);
        rd("rb_reg2", 2'd2, 8'h03);
        wr(2'd1, 8'h0B);
        load();
        chk("half_plusone", {15'd0, PLUSONE}, 16'd1);
        chk("half_s", {15'd0, S}, 16'd1);
        BLK = 1'b0; #1;
        chk("plusone_noblk", {15'd0, PLUSONE}, 16'd0);
        chk("paloe_lag", {15'd0, PAL_OE}, 16'd0);
        cyc();
        chk("paloe_set", {15'd0, PAL_OE}, 16'd1);
        BLK = 1'b1; cyc();

        // flipped down-counting
        wr(2'd1, 8'h0A); wr(2'd2, 8'hC0); wr(2'd3, 8'h01);
        load();
        PIX_STEP = 1'b1; cyc(); cyc(); cyc(); PIX_STEP = 1'b0;
        chk_addr("flip_pix", 8'h08, 8'h02);
        LINE_STEP = 1'b1; cyc(); LINE_STEP = 1'b0;
        chk_addr("flip_line", 8'h07, 8'h85);
        chk("flip_xf", {15'd0, XF}, 16'd1);
        chk("flip_yf", {15'd0, YF}, 16'd1);
        BLK = 1'b0; PIX_STEP = 1'b1; cyc(); PIX_STEP = 1'b0; BLK = 1'b1;
        chk_addr("pix_noblk", 8'h07, 8'h85);

        // Y wrap versus clamp at all-ones
        wr(2'd2, 8'h00); wr(2'd3, 8'h00); wr(2'd0, 8'hFF);
        load();
        LINE_STEP = 1'b1; cyc(); LINE_STEP = 1'b0;
        chk_addr("ywrap", 8'h00, 8'h05);
        wr(2'd3, 8'h02);
        load();
        LINE_STEP = 1'b1; cyc(); LINE_STEP = 1'b0;
        chk_addr("yclamp", 8'h7F, 8'h85);

        // X down-count at zero: clamp holds, wrap goes to all-ones
        wr(2'd1, 8'h00); wr(2'd2, 8'h40); wr(2'd3, 8'h03);
        load();
        PIX_STEP = 1'b1; cyc(); PIX_STEP = 1'b0;
        chk_addr("xclamp0", 8'h7F, 8'h80);
        wr(2'd3, 8'h01);
        load();
        PIX_STEP = 1'b1; cyc(); PIX_STEP = 1'b0;
        chk_addr("xwrap0", 8'h7F, 8'hFF);

        // interrupt / overrun
        wr(2'd3, 8'h00); wr(2'd2, 8'h00);
        ack();
        rd("irq_clr0", 2'd3, 8'h00);
        load();
        rd("irq_set", 2'd3, 8'h80);
        chk("irq_pin", {15'd0, INT}, 16'd1);
        load();
        rd("irq_ovr", 2'd3, 8'hC0);
        ack();
        rd("irq_ack", 2'd3, 8'h00);
        LOAD = 1'b1; ACK = 1'b1; cyc(); LOAD = 1'b0; ACK = 1'b0;
        rd("irq_load_ack", 2'd3, 8'h80);
        wr(2'd2, 8'h20);
        rd("irq_dis_clr", 2'd3, 8'h00);
        load();
        rd("irq_dis_block", 2'd3, 8'h00);

        // frame xor, LOAD priority over PIX_STEP, mid-frame write
        wr(2'd2, 8'h00); wr(2'd3, 8'h04);
        FRAME = 1'b0; PHASE = 1'b1; #1;
        chk("fxor_f0", {15'd0, DRAM_A[7]}, 16'd1);
        FRAME = 1'b1; #1;
        chk("fxor_f1", {15'd0, DRAM_A[7]}, 16'd0);
        FRAME = 1'b0;
        wr(2'd1, 8'h0A);
        LOAD = 1'b1; PIX_STEP = 1'b1; cyc(); LOAD = 1'b0; PIX_STEP = 1'b0;
        chk_addr("load_prio", 8'hFF, 8'h85);
        wr(2'd1, 8'h20);
        chk_addr("midframe_wr", 8'hFF, 8'h85);

        // asynchronous reset mid-operation
        #2;
        nRESET = 1'b0; #1;
        chk_addr("async_rst", 8'h00, 8'h00);
        rd("async_rst_q3", 2'd3, 8'h00);
        nRESET = 1'b1;
        cyc();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
